// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state, widths,
// and the payload latched while an access is stalled on the data bus.
package mem_stage_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 16;
   localparam int unsigned CNT_W           = 8;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned RD_W            = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic              is_load;
      logic              we;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } access_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic              req;
   logic              we;
   logic [DATA_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a retiring instruction or a bubble each cycle,
// captures load data only when asked, and registers the one-cycle error pulses.
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              bubble,
   input  logic              load_data,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic [RD_W-1:0]   rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] rdata,
   input  logic              misalign,
   input  logic              abort,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_rdata,
   output logic              wb_misalign_err,
   output logic              wb_bus_err
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_reg_write    <= 1'b0;
         wb_mem_to_reg   <= 1'b0;
         wb_rd           <= '0;
         wb_alu_result   <= '0;
         wb_rdata        <= '0;
         wb_misalign_err <= 1'b0;
         wb_bus_err      <= 1'b0;
      end else begin
         wb_misalign_err <= misalign;
         wb_bus_err      <= abort;
         // A bubble kills write-back; the ALU result is left as-is since nothing consumes it
         if (bubble) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
         end else begin
            wb_reg_write  <= reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_rd         <= rd;
            wb_alu_result <= alu_result;
         end
         if (load_data) begin
            wb_rdata <= rdata;
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls the pipeline on wait
// states, aborts after TIMEOUT cycles, and feeds the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              RegWrite_in,
   input  logic              MemtoReg_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic [DATA_W-1:0] ALU_result_in,
   input  logic [DATA_W-1:0] reg_read_data_2_in,
   input  logic [RD_W-1:0]   EX_MEM_RegisterRd_in,
   mem_stage_if.master       dmem,
   output logic              MEM_Stall,
   output logic              RegWrite_out,
   output logic              MemtoReg_out,
   output logic [DATA_W-1:0] mem_read_data_out,
   output logic [DATA_W-1:0] ALU_result_out,
   output logic [RD_W-1:0]   MEM_WB_RegisterRd_out,
   output logic              misalign_err,
   output logic              bus_err
);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   access_t           lat, lat_nx;

   logic              access_c, misaligned_c, is_load_c;
   logic              req_c, we_c, stall_c;
   logic [DATA_W-1:0] addr_c, wdata_c;
   logic              bubble_c, load_data_c, misalign_c, abort_c;
   logic              wb_reg_write_c, wb_mem_to_reg_c;
   logic [RD_W-1:0]   wb_rd_c;
   logic [DATA_W-1:0] wb_alu_c;

   assign access_c     = MemRead_in | MemWrite_in;
   assign misaligned_c = access_c & (ALU_result_in[1:0] != 2'b00);
   assign is_load_c    = MemRead_in & ~MemWrite_in;

   // State, wait counter and latched access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         lat   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         lat   <= lat_nx;
      end
   end

   // Next-state, bus drive and write-back selection
   always_comb begin
      state_nx        = state;
      cnt_nx          = cnt;
      lat_nx          = lat;
      req_c           = 1'b0;
      we_c            = 1'b0;
      addr_c          = '0;
      wdata_c         = '0;
      stall_c         = 1'b0;
      bubble_c        = 1'b0;
      load_data_c     = 1'b0;
      misalign_c      = 1'b0;
      abort_c         = 1'b0;
      wb_reg_write_c  = RegWrite_in;
      wb_mem_to_reg_c = MemtoReg_in;
      wb_rd_c         = EX_MEM_RegisterRd_in;
      wb_alu_c        = ALU_result_in;

      case (state)
         ST_IDLE: begin
            if (misaligned_c) begin
               bubble_c   = 1'b1;
               misalign_c = 1'b1;
            end else if (access_c) begin
               req_c   = 1'b1;
               we_c    = MemWrite_in;
               addr_c  = ALU_result_in;
               wdata_c = reg_read_data_2_in;
               if (dmem.ready) begin
                  load_data_c = is_load_c;
               end else begin
                  stall_c           = 1'b1;
                  bubble_c          = 1'b1;
                  lat_nx.reg_write  = RegWrite_in;
                  lat_nx.mem_to_reg = MemtoReg_in;
                  lat_nx.is_load    = is_load_c;
                  lat_nx.we         = MemWrite_in;
                  lat_nx.rd         = EX_MEM_RegisterRd_in;
                  lat_nx.addr       = ALU_result_in;
                  lat_nx.wdata      = reg_read_data_2_in;
                  cnt_nx            = '0;
                  state_nx          = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            req_c           = 1'b1;
            we_c            = lat.we;
            addr_c          = lat.addr;
            wdata_c         = lat.wdata;
            wb_reg_write_c  = lat.reg_write;
            wb_mem_to_reg_c = lat.mem_to_reg;
            wb_rd_c         = lat.rd;
            wb_alu_c        = lat.addr;
            if (dmem.ready) begin
               load_data_c = lat.is_load;
               state_nx    = ST_IDLE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               // Give up: release the pipeline and retire nothing
               abort_c  = 1'b1;
               bubble_c = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
               if (cnt != {CNT_W{1'b1}}) begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Reset must silence the combinational request/stall path immediately
   assign dmem.req   = req_c & reset_n;
   assign dmem.we    = we_c;
   assign dmem.addr  = addr_c;
   assign dmem.wdata = wdata_c;
   assign MEM_Stall  = stall_c & reset_n;

   mem_wb_reg u_mem_wb_reg (
      .clk             (clk),
      .reset_n         (reset_n),
      .bubble          (bubble_c),
      .load_data       (load_data_c),
      .reg_write       (wb_reg_write_c),
      .mem_to_reg      (wb_mem_to_reg_c),
      .rd              (wb_rd_c),
      .alu_result      (wb_alu_c),
      .rdata           (dmem.rdata),
      .misalign        (misalign_c),
      .abort           (abort_c),
      .wb_reg_write    (RegWrite_out),
      .wb_mem_to_reg   (MemtoReg_out),
      .wb_rd           (MEM_WB_RegisterRd_out),
      .wb_alu_result   (ALU_result_out),
      .wb_rdata        (mem_read_data_out),
      .wb_misalign_err (misalign_err),
      .wb_bus_err      (bus_err)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: instruction-level reference model feeding a
// scoreboard queue, checked every cycle by an independent monitor.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
   logic [31:0] ALU_result_in, reg_read_data_2_in;
   logic [4:0]  EX_MEM_RegisterRd_in;
   logic        MEM_Stall, RegWrite_out, MemtoReg_out, misalign_err, bus_err;
   logic [31:0] mem_read_data_out, ALU_result_out;
   logic [4:0]  MEM_WB_RegisterRd_out;

   always #5 clk = ~clk;

   mem_stage_if dmem_bus();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .RegWrite_in           (RegWrite_in),
      .MemtoReg_in           (MemtoReg_in),
      .MemRead_in            (MemRead_in),
      .MemWrite_in           (MemWrite_in),
      .ALU_result_in         (ALU_result_in),
      .reg_read_data_2_in    (reg_read_data_2_in),
      .EX_MEM_RegisterRd_in  (EX_MEM_RegisterRd_in),
      .dmem                  (dmem_bus),
      .MEM_Stall             (MEM_Stall),
      .RegWrite_out          (RegWrite_out),
      .MemtoReg_out          (MemtoReg_out),
      .mem_read_data_out     (mem_read_data_out),
      .ALU_result_out        (ALU_result_out),
      .MEM_WB_RegisterRd_out (MEM_WB_RegisterRd_out),
      .misalign_err          (misalign_err),
      .bus_err               (bus_err)
   );

   // Expected view of one cycle: bus/stall during it, WB outputs at its start
   typedef struct {
      logic        stall, req, we;
      logic [31:0] addr, wdata;
      logic        rw, mtr;
      logic [4:0]  rd;
      logic [31:0] alu, rdata;
      logic        chk_alu, mis, bus;
   } rec_t;

   rec_t q[$];
   int   errors = 0;
   int   checks = 0;

   logic        m_rw, m_mtr, m_mis, m_bus, m_alu_ok;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_inputs(input logic mr, input logic mw, input logic rw, input logic mtr,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
      MemRead_in           = mr;
      MemWrite_in          = mw;
      RegWrite_in          = rw;
      MemtoReg_in          = mtr;
      EX_MEM_RegisterRd_in = rd;
      ALU_result_in        = alu;
      reg_read_data_2_in   = wd;
   endtask

   task automatic model_clear();
      m_rw = 0; m_mtr = 0; m_mis = 0; m_bus = 0; m_alu_ok = 1;
      m_rd = '0; m_alu = '0; m_rdata = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"},   32'(dmem_bus.req), 32'd0);
      chk({tag, "_stall"}, 32'(MEM_Stall), 32'd0);
      chk({tag, "_rw"},    32'(RegWrite_out), 32'd0);
      chk({tag, "_mtr"},   32'(MemtoReg_out), 32'd0);
      chk({tag, "_rd"},    32'(MEM_WB_RegisterRd_out), 32'd0);
      chk({tag, "_rdata"}, mem_read_data_out, 32'd0);
      chk({tag, "_alu"},   ALU_result_out, 32'd0);
      chk({tag, "_mis"},   32'(misalign_err), 32'd0);
      chk({tag, "_bus"},   32'(bus_err), 32'd0);
   endtask

   // One instruction through MEM; delay = ready-low cycles before ready is given
   task automatic do_instr(input logic mr, input logic mw, input logic rw, input logic mtr,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                           input int delay, input logic [31:0] rdat, input int reset_at);
      logic acc, mis, ld, rdy;
      int   n;
      rec_t r;
      acc = mr | mw;
      mis = acc && (alu[1:0] != 2'b00);
      ld  = mr & ~mw;
      if (!acc || mis)              n = 1;
      else if (delay <= int'(TO))   n = delay + 1;
      else                          n = int'(TO) + 1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (k == reset_at) begin
            reset_n = 1'b0;
            set_inputs(0, 0, 0, 0, '0, '0, '0);
            dmem_bus.ready = 1'b0;
            #1;
            check_all_zero("reset_in_wait");
            model_clear();
            #1 reset_n = 1'b1;
            return;
         end
         if (k == 0) set_inputs(mr, mw, rw, mtr, rd, alu, wd);
         else set_inputs(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         5'($urandom), $urandom, $urandom);
         rdy = acc && !mis && (k == delay);
         dmem_bus.ready = acc ? rdy : 1'($urandom);
         dmem_bus.rdata = rdy ? rdat : $urandom;

         r.stall = acc && !mis && !rdy && (k != int'(TO));
         r.req   = acc && !mis;
         r.we    = mw;
         r.addr  = alu;
         r.wdata = wd;
         r.rw = m_rw; r.mtr = m_mtr; r.rd = m_rd; r.alu = m_alu; r.rdata = m_rdata;
         r.chk_alu = m_alu_ok; r.mis = m_mis; r.bus = m_bus;
         q.push_back(r);

         m_mis = 0; m_bus = 0;
         if (!acc || rdy) begin
            m_rw = rw; m_mtr = mtr; m_rd = rd; m_alu = alu; m_alu_ok = 1;
            if (acc && ld) m_rdata = rdat;
         end else begin
            m_rw = 0; m_mtr = 0; m_rd = '0; m_alu_ok = 0;
            if (mis) m_mis = 1;
            else if (k == n - 1) m_bus = 1;
         end
      end
   endtask

   task automatic nop();
      do_instr(0, 0, 0, 0, '0, '0, '0, 0, '0, -1);
   endtask

   // Monitor: compares one scoreboard entry per cycle on the falling edge
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            r = q.pop_front();
            chk("stall",   32'(MEM_Stall), 32'(r.stall));
            chk("req",     32'(dmem_bus.req), 32'(r.req));
            if (r.req) begin
               chk("we",    32'(dmem_bus.we), 32'(r.we));
               chk("addr",  dmem_bus.addr, r.addr);
               chk("wdata", dmem_bus.wdata, r.wdata);
            end
            chk("reg_write", 32'(RegWrite_out), 32'(r.rw));
            chk("mem_to_reg", 32'(MemtoReg_out), 32'(r.mtr));
            chk("rd_out",    32'(MEM_WB_RegisterRd_out), 32'(r.rd));
            chk("rdata_out", mem_read_data_out, r.rdata);
            chk("misalign_err", 32'(misalign_err), 32'(r.mis));
            chk("bus_err",   32'(bus_err), 32'(r.bus));
            if (r.chk_alu) chk("alu_out", ALU_result_out, r.alu);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic        mr, mw;
      logic [31:0] a;
      int          sel, dly;
      reset_n = 1'b0;
      set_inputs(0, 0, 0, 0, '0, '0, '0);
      dmem_bus.ready = 1'b0;
      dmem_bus.rdata = '0;
      model_clear();
      #2;
      check_all_zero("reset");
      #10 reset_n = 1'b1;

      do_instr(0, 0, 1, 0, 5'd5, 32'h0000_00AA, '0, 0, '0, -1);          // R-type
      do_instr(1, 0, 1, 1, 5'd7, 32'h100, '0, 0, 32'hDEAD_BEEF, -1);     // zero-wait load
      do_instr(0, 1, 0, 0, 5'd0, 32'h200, 32'h1234, 3, '0, -1);          // store, 3 waits
      do_instr(1, 0, 1, 1, 5'd9, 32'h300, '0, 1000, '0, -1);             // timeout
      nop();
      do_instr(1, 0, 1, 1, 5'd3, 32'h102, '0, 0, 32'h5555_5555, -1);     // misaligned
      nop();
      do_instr(1, 0, 1, 1, 5'd4, 32'h400, '0, 1000, '0, 2);              // reset in WAIT
      nop();
      nop();
      do_instr(1, 0, 1, 1, 5'd6, 32'h500, '0, int'(TO) - 1, 32'hCAFE_0001, -1);
      do_instr(1, 0, 1, 1, 5'd8, 32'h504, '0, int'(TO), 32'hCAFE_0002, -1);
      do_instr(1, 1, 1, 1, 5'd10, 32'h508, 32'h77, 2, 32'hBAD0_BAD0, -1); // write wins
      nop();

      for (int i = 0; i < 150; i++) begin
         sel = int'($urandom_range(0, 3));
         mr  = (sel == 1) || (sel == 3);
         mw  = (sel == 2) || (sel == 3);
         a   = $urandom;
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         dly = int'($urandom_range(0, 9));
         if (dly < 3)      dly = 0;
         else if (dly < 8) dly = int'($urandom_range(1, 4));
         else              dly = int'($urandom_range(TO - 1, TO + 2));
         do_instr(mr, mw, 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom,
                  dly, $urandom, -1);
      end
      nop();
      nop();

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
